// File: rtl/uart_tx_fsm_if.sv
// Handshake/serializer bundle for the UART transmit frame sequencer.
// master = upstream source plus serializer, slave = uart_tx_fsm.
interface uart_tx_fsm_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_data;
  logic                  ser_done;
  logic [DATA_WIDTH-1:0] ser_data_in;
  logic                  ser_en;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, ser_data, ser_done,
    input  ser_data_in, ser_en, tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, ser_data, ser_done,
    output ser_data_in, ser_en, tx_out, busy
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN for a second stop bit (adds state STOP2).
module uart_tx_fsm #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fsm_if.slave  bus
);
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] START  = 3'd1;
  localparam logic [STATE_W-1:0] DATA   = 3'd2;
  localparam logic [STATE_W-1:0] PARITY = 3'd3;
  localparam logic [STATE_W-1:0] STOP   = 3'd4;
`ifdef UART_TX_STOP2_EN
  localparam logic [STATE_W-1:0] STOP2  = 3'd5;
`endif

  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    state_nxt;
  logic                  accept_c;
  logic                  tx_c;
  logic                  ser_en_c;
  logic                  busy_c;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  parity_q;
  logic                  parity_nxt_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and line decode; outputs depend only on state, latches and serializer bit
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    tx_c      = 1'b1;
    ser_en_c  = 1'b0;
    busy_c    = 1'b1;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.data_valid) begin
          accept_c  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_c      = 1'b0;
        ser_en_c  = 1'b1;
        state_nxt = DATA;
      end
      DATA: begin
        tx_c     = bus.ser_data;
        ser_en_c = 1'b1;
        if (bus.ser_done) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_c      = parity_q;
        state_nxt = STOP;
      end
`ifdef UART_TX_STOP2_EN
      STOP: state_nxt = STOP2;
      STOP2: begin
        if (bus.data_valid) begin
          accept_c  = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
`else
      STOP: begin
        if (bus.data_valid) begin
          accept_c  = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        busy_c    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign parity_nxt_c = bus.par_typ ? ~^bus.p_data : ^bus.p_data;

  // Frame latches: captured only on acceptance so mid-frame input changes are invisible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
    end else if (accept_c) begin
      data_q   <= bus.p_data;
      par_en_q <= bus.par_en;
      parity_q <= parity_nxt_c;
    end
  end

  assign bus.ser_data_in = data_q;
  assign bus.ser_en      = ser_en_c;
  assign bus.tx_out      = tx_c;
  assign bus.busy        = busy_c;
endmodule
